// File: rtl/geometry_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// geometry_fetch_sequencer : bursts single WishBone reads through the master,
// packs WORDS_PER_VEC words per vector and writes vectors to the register file.
// Optional watchdog: GEOMETRY_FETCH_TIMEOUT_EN.   Revision: 1.0
// ============================================================================
module geometry_fetch_sequencer #(
   parameter int WORD_W        = 32,
   parameter int WORDS_PER_VEC = 3,
   parameter int ADDR_W        = 32,
   parameter int RADDR_W       = 7,
   parameter int CNT_W         = 8,
   parameter int TIMEOUT_CYC   = 1024
) (
   input  logic                              Clock,
   input  logic                              Reset,
   input  logic                              iStart,
   input  logic [ADDR_W-1:0]                 iBaseAddress,
   input  logic [CNT_W-1:0]                  iVecCount,
   input  logic [RADDR_W-1:0]                iDestReg,
   input  logic                              iAbort,
   output logic                              oBusy,
   output logic                              oDone,
   output logic                              oError,
   output logic                              oWbmEnable,
   output logic                              oWbmBusCycType,
   output logic [ADDR_W-1:0]                 oWbmAddress,
   output logic                              oWbmAddressSet,
   input  logic                              iWbmDataReady,
   input  logic [WORD_W-1:0]                 iWbmData,
   output logic                              oRegWrite,
   output logic [RADDR_W-1:0]                oRegAddr,
   output logic [WORD_W*WORDS_PER_VEC-1:0]   oRegData
);

   localparam logic WB_SIMPLE_READ_CYCLE = 1'b0;
   localparam int   IDX_W = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_VEC - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SET_ADDR = 3'd1,
      ST_FETCH    = 3'd2,
      ST_WRITE    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        base_q, base_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [CNT_W-1:0]         vec_done_q, vec_done_d;
   logic [RADDR_W-1:0]       dest_q, dest_d;
   logic [IDX_W-1:0]         word_idx_q, word_idx_d;
   logic                     error_q, error_d;
   // Lane 0 sits in the most significant slot so word 0 lands in the top bits.
   logic [0:WORDS_PER_VEC-1][WORD_W-1:0] lanes_q, lanes_d;

   logic last_vec;
   logic timeout_hit;

   assign last_vec = (vec_done_q == count_q - CNT_W'(1));

`ifdef GEOMETRY_FETCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   // Held at zero outside FETCH, so entering FETCH always starts a fresh count.
   always_comb begin
      wd_d = '0;
      if (state_q == ST_FETCH && !iWbmDataReady) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   assign timeout_hit = (state_q == ST_FETCH) && !iWbmDataReady &&
                        (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = TIMEOUT_CYC;
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      count_d        = count_q;
      vec_done_d     = vec_done_q;
      dest_d         = dest_q;
      word_idx_d     = word_idx_q;
      error_d        = error_q;
      lanes_d        = lanes_q;

      oWbmEnable     = 1'b0;
      oWbmAddressSet = 1'b0;
      oWbmAddress    = '0;
      oRegWrite      = 1'b0;
      oRegAddr       = '0;
      oRegData       = '0;
      oDone          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               base_d     = iBaseAddress;
               count_d    = iVecCount;
               dest_d     = iDestReg;
               vec_done_d = '0;
               word_idx_d = '0;
               lanes_d    = '0;
               error_d    = 1'b0;
               state_d    = (iVecCount == '0) ? ST_DONE : ST_SET_ADDR;
            end
         end

         ST_SET_ADDR: begin
            oWbmAddressSet = 1'b1;
            oWbmAddress    = base_q;
            state_d        = iAbort ? ST_DONE : ST_FETCH;
         end

         ST_FETCH: begin
            oWbmEnable = 1'b1;
            if (iAbort) begin
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else if (iWbmDataReady) begin
               lanes_d[word_idx_q] = iWbmData;
               if (word_idx_q == LAST_IDX) begin
                  word_idx_d = '0;
                  state_d    = ST_WRITE;
               end else begin
                  word_idx_d = word_idx_q + IDX_W'(1);
               end
            end
         end

         ST_WRITE: begin
            oRegWrite  = 1'b1;
            oRegAddr   = dest_q;
            oRegData   = lanes_q;
            oWbmEnable = !last_vec;
            dest_d     = dest_q + RADDR_W'(1);
            vec_done_d = vec_done_q + CNT_W'(1);
            if (last_vec || iAbort) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
               // The master keeps streaming while we write; bank this word as lane 0.
               if (iWbmDataReady) begin
                  lanes_d[0] = iWbmData;
                  word_idx_d = IDX_W'(1);
               end
            end
         end

         ST_DONE: begin
            oDone   = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign oBusy          = (state_q != ST_IDLE);
   assign oError         = error_q;
   assign oWbmBusCycType = WB_SIMPLE_READ_CYCLE;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         vec_done_q <= '0;
         dest_q     <= '0;
         word_idx_q <= '0;
         error_q    <= 1'b0;
         lanes_q    <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         vec_done_q <= vec_done_d;
         dest_q     <= dest_d;
         word_idx_q <= word_idx_d;
         error_q    <= error_d;
         lanes_q    <= lanes_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_geometry_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_geometry_fetch_sequencer : directed bench with a simple ACK-gap slave.
// Revision: 1.0
// ============================================================================
module tb_geometry_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iStart;
   logic [31:0] iBaseAddress;
   logic [7:0]  iVecCount;
   logic [6:0]  iDestReg;
   logic        iAbort;
   logic        oBusy, oDone, oError, oWbmEnable, oWbmBusCycType;
   logic [31:0] oWbmAddress;
   logic        oWbmAddressSet;
   logic        iWbmDataReady;
   logic [31:0] iWbmData;
   logic        oRegWrite;
   logic [6:0]  oRegAddr;
   logic [95:0] oRegData;

   always #5 Clock = ~Clock;

   geometry_fetch_sequencer #(
      .WORD_W(32), .WORDS_PER_VEC(3), .ADDR_W(32), .RADDR_W(7), .CNT_W(8), .TIMEOUT_CYC(1024)
   ) dut (
      .Clock(Clock), .Reset(Reset), .iStart(iStart), .iBaseAddress(iBaseAddress),
      .iVecCount(iVecCount), .iDestReg(iDestReg), .iAbort(iAbort), .oBusy(oBusy),
      .oDone(oDone), .oError(oError), .oWbmEnable(oWbmEnable),
      .oWbmBusCycType(oWbmBusCycType), .oWbmAddress(oWbmAddress),
      .oWbmAddressSet(oWbmAddressSet), .iWbmDataReady(iWbmDataReady),
      .iWbmData(iWbmData), .oRegWrite(oRegWrite), .oRegAddr(oRegAddr),
      .oRegData(oRegData)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Slave: waits `gap` idle cycles, then ACKs one word, while enable is high.
   logic        slave_on = 1'b0;
   int          gap      = 0;
   int          gap_cnt  = 0;
   int          sent     = 0;
   logic [31:0] next_word;

   task automatic tick();
      @(posedge Clock);
      if (iWbmDataReady) sent++;
      #1;
      if (slave_on && oWbmEnable) begin
         if (gap_cnt == gap) begin
            iWbmDataReady = 1'b1;
            iWbmData      = next_word;
            next_word     = next_word + 32'd1;
            gap_cnt       = 0;
         end else begin
            iWbmDataReady = 1'b0;
            gap_cnt++;
         end
      end else begin
         iWbmDataReady = 1'b0;
         gap_cnt       = 0;
      end
   endtask

   // Passive monitor of register writes, done pulses, address sets and enable rises.
   int          wr_n = 0, done_n = 0, set_n = 0, rise_n = 0;
   logic [6:0]  wr_addr [64];
   logic [95:0] wr_data [64];
   logic [31:0] set_addr = '0;
   logic        prev_en  = 1'b0;

   always @(negedge Clock) begin
      if (oRegWrite) begin
         wr_addr[wr_n % 64] <= oRegAddr;
         wr_data[wr_n % 64] <= oRegData;
         wr_n               <= wr_n + 1;
      end
      if (oDone) done_n <= done_n + 1;
      if (oWbmAddressSet) begin
         set_n    <= set_n + 1;
         set_addr <= oWbmAddress;
      end
      if (oWbmEnable && !prev_en) rise_n <= rise_n + 1;
      prev_en <= oWbmEnable;
   end

   task automatic start(input logic [31:0] base, input logic [7:0] cnt, input logic [6:0] dest);
      iStart       = 1'b1;
      iBaseAddress = base;
      iVecCount    = cnt;
      iDestReg     = dest;
      tick();
      iStart       = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (oDone) break;
         tick();
      end
      check(tag, oDone, 1'b1);
   endtask

   int w0, d0, s0, r0;

   initial begin
      Reset = 1'b0; iStart = 1'b0; iBaseAddress = '0; iVecCount = '0; iDestReg = '0;
      iAbort = 1'b0; iWbmDataReady = 1'b0; iWbmData = '0; next_word = '0;
      repeat (3) tick();
      check("rst_ctrl", {oBusy, oDone, oError, oWbmEnable, oWbmBusCycType, oWbmAddress,
                         oWbmAddressSet, oRegWrite, oRegAddr}, '0);
      check("rst_data", oRegData, '0);
      Reset = 1'b1;
      tick();

      // Two vectors, back-to-back ACKs; word D arrives during the first WRITE.
      w0 = wr_n; d0 = done_n; s0 = set_n;
      slave_on = 1'b1; gap = 0; next_word = 32'hA;
      start(32'h100, 8'd2, 7'h10);
      check("t1_busy", oBusy, 1'b1);
      wait_done("t1_done");
      tick();
      check("t1_busy_low", oBusy, 1'b0);
      check("t1_wr_cnt",   wr_n - w0, 2);
      check("t1_addr0",    wr_addr[w0], 7'h10);
      check("t1_data0",    wr_data[w0], {32'hA, 32'hB, 32'hC});
      check("t1_addr1",    wr_addr[w0 + 1], 7'h11);
      check("t1_data1",    wr_data[w0 + 1], {32'hD, 32'hE, 32'hF});
      check("t1_done_cnt", done_n - d0, 1);
      check("t1_set_cnt",  set_n - s0, 1);
      check("t1_set_addr", set_addr, 32'h100);
      check("t1_error",    oError, 1'b0);

      // Zero vectors: straight to DONE, no bus activity.
      w0 = wr_n; s0 = set_n; r0 = rise_n;
      start(32'h400, 8'd0, 7'h05);
      check("t2_done", oDone, 1'b1);
      tick();
      check("t2_done_low", oDone, 1'b0);
      check("t2_busy_low", oBusy, 1'b0);
      tick();
      check("t2_no_rise",  rise_n - r0, 0);
      check("t2_no_write", wr_n - w0, 0);
      check("t2_no_set",   set_n - s0, 0);

      // Slow slave, one vector; a start while busy must be ignored.
      w0 = wr_n; s0 = set_n; r0 = rise_n;
      gap = 5; next_word = 32'h11;
      start(32'h500, 8'd1, 7'h40);
      repeat (3) tick();
      iStart = 1'b1; iBaseAddress = 32'h999; iVecCount = 8'd5; iDestReg = 7'h01;
      tick();
      iStart = 1'b0;
      wait_done("t3_done");
      tick();
      check("t3_wr_cnt",   wr_n - w0, 1);
      check("t3_addr",     wr_addr[w0], 7'h40);
      check("t3_data",     wr_data[w0], {32'h11, 32'h12, 32'h13});
      check("t3_one_rise", rise_n - r0, 1);
      check("t3_set_cnt",  set_n - s0, 1);
      check("t3_set_addr", set_addr, 32'h500);
      check("t3_en_low",   oWbmEnable, 1'b0);

      // Abort after the 4th of 6 words: only vector 0 is written.
      w0 = wr_n; d0 = done_n;
      gap = 0; next_word = 32'h1; sent = 0;
      start(32'h200, 8'd2, 7'h20);
      for (int i = 0; i < 100; i++) begin
         if (sent >= 4) break;
         tick();
      end
      check("t4_sent", sent, 4);
      iAbort = 1'b1;
      tick();
      iAbort = 1'b0;
      check("t4_done", oDone, 1'b1);
      tick();
      check("t4_wr_cnt",   wr_n - w0, 1);
      check("t4_addr",     wr_addr[w0], 7'h20);
      check("t4_data",     wr_data[w0], {32'h1, 32'h2, 32'h3});
      check("t4_done_cnt", done_n - d0, 1);
      check("t4_error",    oError, 1'b0);

      w0 = wr_n;
      next_word = 32'h7;
      start(32'h300, 8'd1, 7'h30);
      wait_done("t4b_done");
      tick();
      check("t4b_wr_cnt",   wr_n - w0, 1);
      check("t4b_addr",     wr_addr[w0], 7'h30);
      check("t4b_data",     wr_data[w0], {32'h7, 32'h8, 32'h9});
      check("t4b_set_addr", set_addr, 32'h300);

      // Reset asserted mid-FETCH, then a clean repeat of the first scenario.
      w0 = wr_n;
      next_word = 32'h50;
      start(32'h600, 8'd2, 7'h60);
      repeat (3) tick();
      check("t5_in_fetch", oWbmEnable, 1'b1);
      Reset = 1'b0;
      tick();
      check("t5_rst_ctrl", {oBusy, oDone, oError, oWbmEnable, oWbmBusCycType, oWbmAddress,
                            oWbmAddressSet, oRegWrite, oRegAddr}, '0);
      check("t5_rst_data", oRegData, '0);
      Reset = 1'b1;
      tick();
      next_word = 32'hA;
      start(32'h100, 8'd2, 7'h10);
      wait_done("t5_done");
      tick();
      check("t5_wr_cnt", wr_n - w0, 2);
      check("t5_data0",  wr_data[w0], {32'hA, 32'hB, 32'hC});
      check("t5_data1",  wr_data[w0 + 1], {32'hD, 32'hE, 32'hF});
      check("t5_addr1",  wr_addr[w0 + 1], 7'h11);

      // Destination address wraps modulo 128.
      w0 = wr_n;
      next_word = 32'h70;
      start(32'h700, 8'd2, 7'h7F);
      wait_done("t6_done");
      tick();
      check("t6_wr_cnt", wr_n - w0, 2);
      check("t6_addr0",  wr_addr[w0], 7'h7F);
      check("t6_addr1",  wr_addr[w0 + 1], 7'h00);
      check("t6_data1",  wr_data[w0 + 1], {32'h73, 32'h74, 32'h75});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
